// File: rtl/gb_mem_pkg.sv
// Shared memory-map types and constants for the OAM DMA engine.
// Optional feature macro: OAM_DMA_ECHO_MIRROR_EN (fold echo-RAM pages E0..FF onto C0..DF).
package gb_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } dma_state_t;

  localparam logic [15:0] OAM_BASE_DEFAULT = 16'hFE00;

  // Source page as it is latched at start.
  function automatic logic [7:0] map_page(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_MIRROR_EN
    return (p >= 8'hE0) ? (p - 8'h20) : p;
`else
    return p;
`endif
  endfunction

endpackage

// File: rtl/oam_dma_if.sv
// Memory-bus bundle between the DMA engine (master) and the memory fabric (slave).
interface oam_dma_if;
  logic [15:0] dma_addr;
  logic        dma_re;
  logic        dma_we;
  logic [7:0]  dma_data_out;
  logic        dma_data_oe;
  logic [7:0]  dma_data_in;

  modport master (
    output dma_addr, dma_re, dma_we, dma_data_out, dma_data_oe,
    input  dma_data_in
  );

  modport slave (
    input  dma_addr, dma_re, dma_we, dma_data_out, dma_data_oe,
    output dma_data_in
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA: copies LENGTH bytes from {page,00} to OAM_BASE, one read then one write per byte.
// Latency 2*LENGTH active cycles then a one-cycle done; no backpressure, a new start restarts.
module oam_dma
  import gb_mem_pkg::*;
#(
  parameter int unsigned LENGTH   = 160,
  parameter logic [15:0] OAM_BASE = OAM_BASE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  page,
  oam_dma_if.master   bus,
  output logic        dma_active,
  output logic        done
);

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

  dma_state_t state, state_d;
  logic [7:0] idx, idx_d;
  logic [7:0] page_q, page_d;
  logic [7:0] buffer, buffer_d;
  logic       done_q, done_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      idx    <= 8'h00;
      page_q <= 8'h00;
      buffer <= 8'h00;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      page_q <= page_d;
      buffer <= buffer_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    page_d   = page_q;
    buffer_d = buffer;
    done_d   = 1'b0;
    case (state)
      ST_READ: begin
        buffer_d = bus.dma_data_in;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        if (idx == LAST_IDX) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx + 8'd1;
          state_d = ST_READ;
        end
      end
      default: ;
    endcase
    // A start in any state (including the final write) restarts from byte 0 and drops done.
    if (start) begin
      state_d = ST_READ;
      idx_d   = 8'h00;
      page_d  = map_page(page);
      done_d  = 1'b0;
    end
  end

  always_comb begin
    bus.dma_addr     = 16'h0000;
    bus.dma_re       = 1'b0;
    bus.dma_we       = 1'b0;
    bus.dma_data_out = 8'h00;
    bus.dma_data_oe  = 1'b0;
    dma_active       = 1'b0;
    case (state)
      ST_READ: begin
        bus.dma_addr = {page_q, idx};
        bus.dma_re   = 1'b1;
        dma_active   = 1'b1;
      end
      ST_WRITE: begin
        bus.dma_addr     = OAM_BASE + {8'h00, idx};
        bus.dma_we       = 1'b1;
        bus.dma_data_out = buffer;
        bus.dma_data_oe  = 1'b1;
        dma_active       = 1'b1;
      end
      default: ;
    endcase
  end

  assign done = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a 160-byte and a 4-byte instance share stimulus; a transfer-level model predicts every bus cycle.
module tb_oam_dma;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] page;
  logic       act_a, done_a, act_b, done_b;

  oam_dma_if bus_a ();
  oam_dma_if bus_b ();

  logic [7:0] mem [0:65535];

  assign bus_a.dma_data_in = bus_a.dma_re ? mem[bus_a.dma_addr] : 8'h00;
  assign bus_b.dma_data_in = bus_b.dma_re ? mem[bus_b.dma_addr] : 8'h00;

  oam_dma #(.LENGTH(160)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start), .page(page),
    .bus(bus_a), .dma_active(act_a), .done(done_a)
  );

  oam_dma #(.LENGTH(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start), .page(page),
    .bus(bus_b), .dma_active(act_b), .done(done_b)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Transfer-level model: a transfer is 2*L bus cycles (even = read byte k/2, odd = write it), then done.
  int         len  [2] = '{160, 4};
  bit         m_on [2];
  logic [7:0] m_pg [2];
  int         m_k  [2];
  bit         m_dn [2];

  int cnt_act  [2];
  int cnt_done [2];

  function automatic logic [7:0] map_pg(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_MIRROR_EN
    if (p >= 8'hE0) return p - 8'h20;
`endif
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_on[d] = 1'b0;
      m_dn[d] = 1'b0;
      m_k[d]  = 0;
      m_pg[d] = 8'h00;
    end
  endtask

  task automatic check_dut(input int d);
    logic [15:0] a_addr, e_addr;
    logic        a_re, a_we, a_oe, a_act, a_done;
    logic        e_re, e_we, e_oe;
    logic [7:0]  a_dout, e_dout;
    string       tag;
    int          bi;
    tag = (d == 0) ? "A" : "B";
    if (d == 0) begin
      a_addr = bus_a.dma_addr; a_re = bus_a.dma_re; a_we = bus_a.dma_we;
      a_oe = bus_a.dma_data_oe; a_dout = bus_a.dma_data_out; a_act = act_a; a_done = done_a;
    end else begin
      a_addr = bus_b.dma_addr; a_re = bus_b.dma_re; a_we = bus_b.dma_we;
      a_oe = bus_b.dma_data_oe; a_dout = bus_b.dma_data_out; a_act = act_b; a_done = done_b;
    end
    e_addr = 16'h0000; e_re = 1'b0; e_we = 1'b0; e_oe = 1'b0; e_dout = 8'h00;
    if (m_on[d]) begin
      bi = m_k[d] / 2;
      if (m_k[d] % 2 == 0) begin
        e_addr = {m_pg[d], 8'(bi)};
        e_re   = 1'b1;
      end else begin
        e_addr = 16'hFE00 + 16'(bi);
        e_we   = 1'b1;
        e_oe   = 1'b1;
        e_dout = mem[{m_pg[d], 8'(bi)}];
      end
    end
    chk({tag, " addr"}, 32'(a_addr), 32'(e_addr));
    chk({tag, " re"}, 32'(a_re), 32'(e_re));
    chk({tag, " we"}, 32'(a_we), 32'(e_we));
    chk({tag, " oe"}, 32'(a_oe), 32'(e_oe));
    chk({tag, " re&we"}, 32'(a_re & a_we), 32'd0);
    if (e_we) chk({tag, " wdata"}, 32'(a_dout), 32'(e_dout));
    chk({tag, " active"}, 32'(a_act), 32'(m_on[d]));
    chk({tag, " done"}, 32'(a_done), 32'(m_dn[d]));
    if (a_act === 1'b1) cnt_act[d]++;
    if (a_done === 1'b1) cnt_done[d]++;
  endtask

  // Apply inputs for one cycle, advance the model across the edge, sample at the next falling edge.
  task automatic tick(input bit st, input logic [7:0] pg);
    start = st;
    page  = pg;
    for (int d = 0; d < 2; d++) begin
      if (st) begin
        m_on[d] = 1'b1; m_pg[d] = map_pg(pg); m_k[d] = 0; m_dn[d] = 1'b0;
      end else if (m_on[d]) begin
        if (m_k[d] == 2 * len[d] - 1) begin
          m_on[d] = 1'b0; m_dn[d] = 1'b1;
        end else begin
          m_k[d]++; m_dn[d] = 1'b0;
        end
      end else begin
        m_dn[d] = 1'b0;
      end
    end
    @(negedge clock);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic clr_cnt();
    for (int d = 0; d < 2; d++) begin
      cnt_act[d]  = 0;
      cnt_done[d] = 0;
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, " A bus"}, {bus_a.dma_addr, 4'(0), bus_a.dma_re, bus_a.dma_we, bus_a.dma_data_oe, act_a, done_a},
        32'd0);
    chk({nm, " B bus"}, {bus_b.dma_addr, 4'(0), bus_b.dma_re, bus_b.dma_we, bus_b.dma_data_oe, act_b, done_b},
        32'd0);
  endtask

  typedef struct {
    logic [7:0]  pg;
    int          run;
    logic [15:0] first_a;
    int          act_a;
    int          act_b;
    int          done_a;
    int          done_b;
  } vec_t;

`ifdef OAM_DMA_ECHO_MIRROR_EN
  localparam logic [15:0] E1_FIRST = 16'hC100;
`else
  localparam logic [15:0] E1_FIRST = 16'hE100;
`endif

  initial begin
    vec_t vecs [4];
    vecs[0] = '{pg: 8'hC0, run: 330, first_a: 16'hC000, act_a: 320, act_b: 8, done_a: 1, done_b: 1};
    vecs[1] = '{pg: 8'h80, run: 12,  first_a: 16'h8000, act_a: 12,  act_b: 8, done_a: 0, done_b: 1};
    vecs[2] = '{pg: 8'hE1, run: 330, first_a: E1_FIRST, act_a: 320, act_b: 8, done_a: 1, done_b: 1};
    vecs[3] = '{pg: 8'h5A, run: 330, first_a: 16'h5A00, act_a: 320, act_b: 8, done_a: 1, done_b: 1};

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    reset_n = 1'b0;
    start   = 1'b0;
    page    = 8'h00;
    model_reset();
    clr_cnt();
    #3;
    check_reset_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    tick(1'b0, 8'h00);

    // Table-driven transfers: start, then run a fixed window and count activity and done pulses.
    for (int v = 0; v < 4; v++) begin
      clr_cnt();
      tick(1'b1, vecs[v].pg);
      chk($sformatf("vec%0d first read", v), 32'(bus_a.dma_addr), 32'(vecs[v].first_a));
      for (int c = 1; c < vecs[v].run; c++) tick(1'b0, 8'h00);
      chk($sformatf("vec%0d A active cycles", v), 32'(cnt_act[0]), 32'(vecs[v].act_a));
      chk($sformatf("vec%0d B active cycles", v), 32'(cnt_act[1]), 32'(vecs[v].act_b));
      chk($sformatf("vec%0d A done count", v), 32'(cnt_done[0]), 32'(vecs[v].done_a));
      chk($sformatf("vec%0d B done count", v), 32'(cnt_done[1]), 32'(vecs[v].done_b));
    end

    // Restart at cycle 50 with a new page: first transfer never signals done.
    clr_cnt();
    tick(1'b1, 8'hC0);
    for (int c = 0; c < 49; c++) tick(1'b0, 8'h00);
    chk("restart A no early done", 32'(cnt_done[0]), 32'd0);
    clr_cnt();
    tick(1'b1, 8'hD0);
    chk("restart first read", 32'(bus_a.dma_addr), 32'hD000);
    for (int c = 1; c < 330; c++) tick(1'b0, 8'h00);
    chk("restart A active cycles", 32'(cnt_act[0]), 32'd320);
    chk("restart A done count", 32'(cnt_done[0]), 32'd1);

    // Asynchronous reset in the middle of a transfer.
    clr_cnt();
    tick(1'b1, 8'hC0);
    for (int c = 0; c < 99; c++) tick(1'b0, 8'h00);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    model_reset();
    @(negedge clock);
    check_reset_outputs("held reset");
    reset_n = 1'b1;
    clr_cnt();
    for (int c = 0; c < 5; c++) tick(1'b0, 8'h00);
    chk("post-reset no done", 32'(cnt_done[0] + cnt_done[1]), 32'd0);
    clr_cnt();
    tick(1'b1, 8'h44);
    for (int c = 1; c < 330; c++) tick(1'b0, 8'h00);
    chk("post-reset A active", 32'(cnt_act[0]), 32'd320);
    chk("post-reset A done", 32'(cnt_done[0]), 32'd1);

    // Start coinciding with the 4-byte instance's final write suppresses its done.
    tick(1'b1, 8'h80);
    for (int c = 0; c < 7; c++) tick(1'b0, 8'h00);
    chk("final write is write", 32'({bus_b.dma_we, bus_b.dma_addr}), 32'({1'b1, 16'hFE03}));
    clr_cnt();
    tick(1'b1, 8'h90);
    chk("coincide B no done", 32'(cnt_done[1]), 32'd0);
    chk("coincide B reread", 32'(bus_b.dma_addr), 32'h9000);
    for (int c = 0; c < 340; c++) tick(1'b0, 8'h00);

    // Random starts and pages, including frequent mid-transfer restarts.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 59) == 0, 8'($urandom));
    end
    for (int c = 0; c < 330; c++) tick(1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
